// File: rtl/mag_peak_search_pkg.sv
// Shared magnitude types and peak-search configuration for the receiver
// timing path.
package mag_peak_search_pkg;

    localparam int unsigned MAG_W = 16;
    typedef logic [MAG_W-1:0] mag_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } mps_state_t;

    localparam int unsigned MPS_WIN_LEN_DEF = 64;

endpackage

// File: rtl/mag_peak_search_if.sv
// Control/data bundle between the magnitude stage, the peak search and the
// timing-alignment controller.
interface mag_peak_search_if
    import mag_peak_search_pkg::*;
#(
    parameter int unsigned WIN_LEN = MPS_WIN_LEN_DEF,
    parameter int unsigned IDX_W   = $clog2(WIN_LEN)
);

    logic             start;
    mag_t             thr_in;
    mag_t             mag_in;
    logic             mag_valid;
    logic             busy;
    logic             done;
    mag_t             peak_val;
    logic [IDX_W-1:0] peak_idx;
    logic             found;

    modport master (
        output start, thr_in, mag_in, mag_valid,
        input  busy, done, peak_val, peak_idx, found
    );

    modport slave (
        input  start, thr_in, mag_in, mag_valid,
        output busy, done, peak_val, peak_idx, found
    );

endinterface

// File: rtl/mag_peak_search_max_track.sv
// Running maximum/index pair: strict-greater update keeps the earliest index on
// ties; the first sample of a window always loads.
module mag_max_track
    import mag_peak_search_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             update,
    input  logic             first,
    input  mag_t             sample,
    input  logic [IDX_W-1:0] idx,
    output mag_t             run_max,
    output logic [IDX_W-1:0] run_idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (init) begin
            run_max <= '0;
            run_idx <= '0;
        end else if (update && (first || sample > run_max)) begin
            run_max <= sample;
            run_idx <= idx;
        end
    end

endmodule

// File: rtl/mag_peak_search.sv
// Windowed peak search over the magnitude stream: reports the largest sample,
// its index within the window, and a strict threshold comparison.
module mag_peak_search
    import mag_peak_search_pkg::*;
#(
    parameter int unsigned WIN_LEN = MPS_WIN_LEN_DEF,
    parameter int unsigned IDX_W   = $clog2(WIN_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    mag_peak_search_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    mps_state_t       state, state_nx;
    logic [IDX_W-1:0] cnt;
    mag_t             thr_q;
    mag_t             run_max;
    logic [IDX_W-1:0] run_idx;
    logic             arm;
    logic             consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A start in SEARCH re-arms in place and swallows any coincident sample.
    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        consume  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    arm      = 1'b1;
                    state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (bus.start) begin
                    arm = 1'b1;
                end else if (bus.mag_valid) begin
                    consume = 1'b1;
                    if (cnt == LAST_IDX) state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    arm      = 1'b1;
                    state_nx = SEARCH;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            thr_q    <= '0;
            bus.busy <= 1'b0;
        end else if (arm) begin
            cnt      <= '0;
            thr_q    <= bus.thr_in;
            bus.busy <= 1'b1;
        end else if (consume) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == LAST_IDX) bus.busy <= 1'b0;
        end
    end

    mag_max_track #(
        .IDX_W (IDX_W)
    ) u_track (
        .clk     (clk),
        .rst     (rst),
        .init    (arm),
        .update  (consume),
        .first   (cnt == '0),
        .sample  (bus.mag_in),
        .idx     (cnt),
        .run_max (run_max),
        .run_idx (run_idx)
    );

    // Results are taken while in DONE, so done and the outputs change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.done     <= 1'b0;
            bus.peak_val <= '0;
            bus.peak_idx <= '0;
            bus.found    <= 1'b0;
        end else begin
            bus.done <= (state == DONE);
            if (state == DONE) begin
                bus.peak_val <= run_max;
                bus.peak_idx <= run_idx;
                bus.found    <= (run_max > thr_q);
            end
        end
    end

endmodule

// File: tb/tb_mag_peak_search.sv
// Bench for mag_peak_search: queue-based window model checked every cycle,
// plus directed windows with literal expectations.
module tb_mag_peak_search;
    import mag_peak_search_pkg::*;

    localparam int unsigned WL = 8;
    localparam int unsigned IW = $clog2(WL);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mag_peak_search_if #(.WIN_LEN(WL)) bus ();

    mag_peak_search #(.WIN_LEN(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int done_count = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: collect each window's valid samples, then pick the peak.
    mag_t q[$];
    bit   m_active = 0, m_pend = 0;
    mag_t m_thr = '0, p_val = '0;
    int   p_idx = 0;
    bit   p_found = 0;
    bit   exp_busy = 0, exp_done = 0, exp_found = 0;
    mag_t exp_val = '0;
    int   exp_idx = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_active = 0; m_pend = 0; m_thr = '0;
            exp_busy = 0; exp_done = 0; exp_found = 0; exp_val = '0; exp_idx = 0;
        end else begin
            exp_done = m_pend;
            if (m_pend) begin
                exp_val = p_val; exp_idx = p_idx; exp_found = p_found;
                m_pend = 0;
            end
            if (bus.start) begin
                m_active = 1; q.delete(); m_thr = bus.thr_in; exp_busy = 1;
            end else if (m_active && bus.mag_valid) begin
                q.push_back(bus.mag_in);
                if (q.size() == WL) begin
                    p_val = q[0]; p_idx = 0;
                    for (int i = 1; i < int'(WL); i++)
                        if (q[i] > p_val) begin p_val = q[i]; p_idx = i; end
                    p_found  = (p_val > m_thr);
                    m_active = 0; exp_busy = 0; m_pend = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("peak_val", 32'(bus.peak_val), 32'(exp_val));
        check("peak_idx", 32'(bus.peak_idx), 32'(exp_idx));
        check("found", 32'(bus.found), 32'(exp_found));
        if (bus.done) done_count++;
    end

    task automatic feed(input bit st, input mag_t thr, input bit v, input mag_t m);
        @(negedge clk);
        bus.start = st; bus.thr_in = thr; bus.mag_valid = v; bus.mag_in = m;
        if (st) start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.start = 0; bus.mag_valid = 0;
            #1;
            if (bus.done) begin lat = cyc - start_cyc; break; end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_window(input mag_t thr, input mag_t s[WL], input bit gaps, output int lat);
        feed(1, thr, 0, '0);
        for (int i = 0; i < int'(WL); i++) begin
            feed(0, thr, 1, s[i]);
            if (gaps && i < int'(WL) - 1) feed(0, thr, 0, mag_t'($urandom));
        end
        wait_done(60, lat);
    endtask

    task automatic check_outs(input string tag, input mag_t v, input int idx, input bit f);
        check({tag, "_val"}, 32'(bus.peak_val), 32'(v));
        check({tag, "_idx"}, 32'(bus.peak_idx), 32'(idx));
        check({tag, "_found"}, 32'(bus.found), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mag_t w[WL];
        int lat, dc;
        rst = 1'b1;
        bus.start = 0; bus.thr_in = '0; bus.mag_in = '0; bus.mag_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check_outs("rst", '0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        w = '{16'd5, 16'd20, 16'd300, 16'd7, 16'd300, 16'd1, 16'd0, 16'd9};
        run_window(16'd100, w, 0, lat);
        check("lat_b2b", 32'(lat), 10);
        check_outs("tie", 16'd300, 2, 1);

        run_window(16'd300, w, 0, lat);
        check_outs("strict", 16'd300, 2, 0);

        w = '{default: '0};
        run_window(16'd0, w, 0, lat);
        check_outs("zeros", '0, 0, 0);

        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'hFFFF};
        run_window(16'd0, w, 0, lat);
        check_outs("ones", 16'hFFFF, 7, 1);

        w = '{16'd10, 16'd20, 16'd30, 16'd50, 16'd5, 16'd5, 16'd5, 16'd5};
        run_window(16'd49, w, 1, lat);
        check("lat_gaps", 32'(lat), 17);
        check_outs("gaps", 16'd50, 3, 1);

        // Abort window A after four samples; restart carries a discarded sample.
        dc = done_count;
        feed(1, 16'd0, 0, '0);
        feed(0, 16'd0, 1, 16'd100);
        feed(0, 16'd0, 1, 16'd900);
        feed(0, 16'd0, 1, 16'd3);
        feed(0, 16'd0, 1, 16'd4);
        #1;
        check_outs("held", 16'd50, 3, 1);
        feed(1, 16'd30, 1, 16'd777);
        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd40, 16'd7};
        for (int i = 0; i < int'(WL); i++) feed(0, 16'd30, 1, w[i]);
        wait_done(20, lat);
        check("lat_abort", 32'(lat), 10);
        check("abort_dones", 32'(done_count - dc), 1);
        check_outs("abort", 16'd40, 6, 1);

        // Asynchronous reset between edges, then start held during reset.
        feed(1, 16'd500, 0, '0);
        feed(0, 16'd500, 1, 16'd1000);
        feed(0, 16'd500, 1, 16'd2000);
        feed(0, 16'd500, 1, 16'd3000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check_outs("arst", '0, 0, 0);
        dc = done_count;
        feed(1, 16'd1, 1, 16'd5);
        @(negedge clk);
        bus.start = 0; bus.mag_valid = 0; rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_start_busy", 32'(bus.busy), 0);
        check("rst_no_done", 32'(done_count - dc), 0);
        w = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
        run_window(16'd8, w, 0, lat);
        check("lat_clean", 32'(lat), 10);
        check_outs("clean", 16'd9, 0, 1);

        // Random traffic: gaps, aborts, re-arm in DONE, ties from a narrow range.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.start     = ($urandom_range(0, 39) == 0);
            bus.thr_in    = mag_t'($urandom_range(0, 31));
            bus.mag_valid = ($urandom_range(0, 3) != 0);
            bus.mag_in    = ($urandom_range(0, 15) == 0) ? mag_t'($urandom)
                                                         : mag_t'($urandom_range(0, 31));
        end
        @(negedge clk);
        bus.start = 0; bus.mag_valid = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mag_peak_search.md
Name: mag_peak_search

Overview:
- Sits directly downstream of the AMBM magnitude stage.
- Consumes the stream of correlation magnitudes (mag_t, one per valid cycle) over a search window of WIN_LEN samples.
- Reports the largest magnitude, its sample index within the window, and whether it exceeds a programmable detection threshold.
- Its result drives symbol-timing alignment in the receiver control path.

Parameters:
- WIN_LEN, 64, number of valid samples per search window; must be ≥ 2.
- IDX_W, $clog2(WIN_LEN), width of the sample index and counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new search and latches thr_in.
- thr_in  in  MAG_W  detection threshold, same raw Q-format as mag_t.
- mag_in  in  MAG_W  magnitude sample (mag_t), unsigned raw.
- mag_valid  in  1  mag_in is valid this cycle; already aligned to the magnitude stage's 1-cycle latency.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when the window completes.
- peak_val  out  MAG_W  largest magnitude of the last completed window.
- peak_idx  out  IDX_W  index (0..WIN_LEN-1) of peak_val within the window.
- found  out  1  peak_val > latched threshold, strictly greater.

Behaviour:
- Reset (asynchronous, active-high), applied any time including mid-search:
  - state=IDLE; busy=0, done=0, found=0, peak_val=0, peak_idx=0.
  - Internal counter, running max, running index and latched threshold all cleared.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 → SEARCH next cycle.
  - On that edge: thr_q←thr_in, cnt←0, run_max←0, run_idx←0, busy←1.
  - mag_valid is ignored in IDLE.
- SEARCH:
  - Each cycle with mag_valid=1: if cnt==0 or mag_in > run_max (strict), then run_max←mag_in and run_idx←cnt.
  - Then cnt←cnt+1.
  - Ties keep the earliest index.
  - A sample of value 0 at cnt==0 still sets run_idx=0.
  - mag_valid=0 cycles hold all state; gaps are allowed, and only valid samples count.
  - When the WIN_LEN-th valid sample (cnt==WIN_LEN-1 with mag_valid) is consumed, go to DONE next cycle. That final sample does participate in the compare.
- DONE (exactly one cycle):
  - done=1.
  - peak_val, peak_idx and found are registered from run_max, run_idx and (run_max > thr_q).
  - These outputs update on the same edge done asserts and hold until the next DONE.
  - busy=0 in DONE.
  - Next state is IDLE, or SEARCH if start=1 in the DONE cycle (re-arm as in IDLE).
- Latency: done asserts one cycle after the clock edge that consumed the last valid sample.
  - Minimum window time is WIN_LEN+2 cycles from start to done, with mag_valid continuously high from the cycle after start.
- start during SEARCH: abort and restart.
  - Counter and running max are re-initialised; the new thr_in is latched.
  - No done is generated for the aborted window, and outputs keep their previous values.
  - A sample with mag_valid coincident with that restarting start is discarded.
- start coincident with rst: rst wins.
- Counter: IDX_W bits. It never wraps in normal operation, because the transition at WIN_LEN-1 precedes the wrap.
- Arithmetic: all compares are unsigned on MAG_W bits. No saturation is required because no arithmetic widens.

Decomposition:
- Shared package data_type:
  - mag_t and MAG_W are reused.
  - Add the state enum mps_state_t {IDLE, SEARCH, DONE} and the localparam MPS_WIN_LEN_DEF=64 for system-level window configuration.
- One natural sub-module: mag_max_track. It holds the running max/index register pair with init/update/hold controls and the strict-greater compare. The top level keeps the FSM, counter, threshold latch and output registers.

Test Plan:
- Reset, then start with thr=100 and WIN_LEN=8 samples {5,20,300,7,300,1,0,9} back-to-back → done at cycle start+10, peak_val=300, peak_idx=2 (first of tie), found=1.
- Same window with thr=300 → peak_val=300, found=0 (strict compare).
- Window of all zeros → peak_val=0, peak_idx=0, found=0; peak of a max-value sample (all ones) at index 7 → peak_idx=7.
- mag_valid toggling 1,0,1,0 with peak 50 at the 4th valid sample → peak_idx=3, done only after 8 valid samples.
- start reasserted after 4 samples of window A (A's peak 900 at idx 1), then window B with peak 40 at idx 6 → single done, peak_val=40, peak_idx=6; prior outputs held during abort.
- rst asserted asynchronously mid-SEARCH (between clock edges) → all outputs 0 immediately, no done; a subsequent start runs a clean full window.
